// File: rtl/piso_tx_pkg.sv
// rtl/piso_tx_pkg.sv - shared state encoding, output bundle and counter-width helper for piso_tx
package piso_pkg;

  typedef logic [1:0] piso_state_t;

  localparam piso_state_t ST_IDLE   = 2'd0;
  localparam piso_state_t ST_SHIFT  = 2'd1;
  localparam piso_state_t ST_PARITY = 2'd2;

  // Every output leaves the block from one of these flops.
  typedef struct packed {
    logic sout;
    logic sout_valid;
    logic busy;
    logic done;
    logic load_ready;
  } piso_out_t;

  // Bit counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - load handshake and serial output bundle between a producer and piso_tx
interface piso_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_bit_cnt.sv
// rtl/piso_bit_cnt.sv - loadable down-counter of remaining frame bits with a zero flag
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);

  // Decrement stops at zero so the count can only be refreshed by a new load.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - MSB-first parallel-in/serial-out transmitter with valid/ready load side
// Defining PISO_TX_PARITY_EN appends one even-parity bit to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);

  piso_state_t      state_q;
  piso_state_t      state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  piso_out_t        out_q;
  piso_out_t        out_d;
  logic             handshake;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q;
  logic             parity_d;
`endif

  assign handshake = bus.load_valid && out_q.load_ready;

  assign bus.sout       = out_q.sout;
  assign bus.sout_valid = out_q.sout_valid;
  assign bus.busy       = out_q.busy;
  assign bus.done       = out_q.done;
  assign bus.load_ready = out_q.load_ready;

  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // Outputs are computed one cycle ahead so the first bit lands the cycle after the handshake.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    out_d    = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        out_d.load_ready = 1'b1;
        if (handshake) begin
          state_d          = ST_SHIFT;
          shreg_d          = bus.load_data;
          cnt_load         = 1'b1;
          out_d.sout       = bus.load_data[WIDTH-1];
          out_d.sout_valid = 1'b1;
          out_d.busy       = 1'b1;
          out_d.load_ready = 1'b0;
`ifdef PISO_TX_PARITY_EN
          parity_d         = ^bus.load_data;
`endif
        end
      end

      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (!cnt_zero) begin
          cnt_dec          = 1'b1;
          out_d.sout       = shreg_q[WIDTH-2];
          out_d.sout_valid = 1'b1;
          out_d.busy       = 1'b1;
        end else begin
`ifdef PISO_TX_PARITY_EN
          state_d          = ST_PARITY;
          out_d.sout       = parity_q;
          out_d.sout_valid = 1'b1;
          out_d.busy       = 1'b1;
`else
          state_d          = ST_IDLE;
          out_d.done       = 1'b1;
          out_d.load_ready = 1'b1;
`endif
        end
      end

`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        state_d          = ST_IDLE;
        out_d.done       = 1'b1;
        out_d.load_ready = 1'b1;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      out_q    <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      out_q    <= out_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - self-checking bench for piso_tx: vector table, corner sequences, random traffic vs frame model
module tb_piso_tx;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = W + PB;

  typedef struct packed {
    logic sout;
    logic sout_valid;
    logic busy;
    logic done;
    logic ready;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_seq;
    logic       exp_par;
    bit         inject;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  obs_t exp_now = '0;
  obs_t exp_q[$];

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: an accepted word becomes FL data/parity beats followed by one done beat.
  function automatic void push_frame(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back('{w[i], 1'b1, 1'b1, 1'b0, 1'b0});
    if (PB == 1) exp_q.push_back('{^w, 1'b1, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_now <= '0;
    end else begin
      if (bus.load_valid && exp_now.ready) push_frame(bus.load_data);
      if (exp_q.size() > 0) exp_now <= exp_q.pop_front();
      else exp_now <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end
  end

  always @(negedge clk) begin
    if (mon_en) chk("model_cycle", {27'd0, bus.sout, bus.sout_valid, bus.busy, bus.done, bus.load_ready}, {27'd0, exp_now});
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.load_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, bus.load_ready}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit inject, output logic [8:0] bits, output int nb);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    wait_ready();
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_data  = 8'($urandom);
    bits = '0;
    nb   = 0;
    while (bus.sout_valid && nb < 12) begin
      bits = {bits[7:0], bus.sout};
      nb++;
      if (inject && nb == 3) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h3C;
      end else if (inject && nb == 4) begin
        bus.load_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  vec_t       tbl[8];
  logic [8:0] bits;
  int         nb;
  logic [8:0] exp_bits;
  logic [31:0] vtr, dtr, str, vexp, dexp, sexp;
  bit         drop;
  bit         seen;

  initial begin
    tbl[0] = '{8'hA5, 8'b1010_0101, 1'b0, 1'b0};
    tbl[1] = '{8'h81, 8'b1000_0001, 1'b0, 1'b1};
    tbl[2] = '{8'h07, 8'b0000_0111, 1'b1, 1'b0};
    tbl[3] = '{8'h03, 8'b0000_0011, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 8'b1111_1111, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'b0000_0000, 1'b0, 1'b0};
    tbl[6] = '{8'h01, 8'b0000_0001, 1'b1, 1'b1};
    tbl[7] = '{8'h3C, 8'b0011_1100, 1'b0, 1'b0};

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    #2 rst = 1'b1;

    // Reset state and release latency
    @(negedge clk);
    chk("reset_outs", {27'd0, bus.sout, bus.sout_valid, bus.busy, bus.done, bus.load_ready}, 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    #1 chk("ready_before_edge", {31'd0, bus.load_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge", {31'd0, bus.load_ready}, 32'd1);

    // Asynchronous assert between edges with no clock edge
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset_outs", {27'd0, bus.sout, bus.sout_valid, bus.busy, bus.done, bus.load_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {31'd0, bus.load_ready}, 32'd1);

    // Vector table: frame contents, length and done pulse
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].inject, bits, nb);
      exp_bits = (PB == 1) ? {tbl[i].exp_seq, tbl[i].exp_par} : {1'b0, tbl[i].exp_seq};
      chk($sformatf("frame_bits_%0h", tbl[i].data), {23'd0, bits}, {23'd0, exp_bits});
      chk($sformatf("frame_len_%0h", tbl[i].data), nb, FL);
      chk($sformatf("frame_done_%0h", tbl[i].data), {30'd0, bus.done, bus.load_ready}, 32'd3);
    end

    // Back-to-back with valid held: second handshake in the done cycle
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    wait_ready();
    @(negedge clk);
    bus.load_data = 8'h00;
    drop = 1'b0;
    vtr = '0; dtr = '0; str = '0;
    for (int c = 0; c < 2 * FL + 2; c++) begin
      vtr[c] = bus.sout_valid;
      dtr[c] = bus.done;
      str[c] = bus.sout;
      if (drop) bus.load_valid = 1'b0;
      if (c > 0 && bus.load_ready) drop = 1'b1;
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    vexp = '0; dexp = '0; sexp = '0;
    for (int c = 0; c < 2 * FL + 2; c++) begin
      vexp[c] = (c < FL) || (c > FL && c <= 2 * FL);
      dexp[c] = (c == FL) || (c == 2 * FL + 1);
      sexp[c] = (c < W);
    end
    chk("b2b_valid_trace", vtr, vexp);
    chk("b2b_done_trace", dtr, dexp);
    chk("b2b_data_trace", str, sexp);

    // Abort mid-frame: no done pulse, frame lost
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hF0;
    wait_ready();
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_frame", {30'd0, bus.sout_valid, bus.busy}, 32'd3);
    #2 rst = 1'b1;
    #1 chk("abort_outs", {28'd0, bus.sout_valid, bus.busy, bus.done, bus.load_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.sout_valid) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

    // Random traffic with occasional resets, checked every cycle by the model
    repeat (600) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 149) == 0);
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_data  = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.load_valid = 1'b0;
    repeat (2 * FL) @(negedge clk);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
